// File: rtl/neopixel_pkg.sv
// Shared types and widths for the NeoPixel channel: encoder FSM states,
// timing-register widths and the default latch-code length.
package neopixel_pkg;

    localparam int T_H_W = 8;
    localparam int T_S_W = 9;
    localparam int RST_CYCLES_DEF = 4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } enc_state_t;

endpackage

// File: rtl/ws28xx_bit_timer.sv
// Per-bit period generator: derives high time and period for the current
// bit and runs the period counter while the encoder is shifting.
module ws28xx_bit_timer
    import neopixel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic             bit_val,
    input  logic [T_H_W-1:0] t0h,
    input  logic [T_S_W-1:0] t0s,
    input  logic [T_H_W-1:0] t1h,
    input  logic [T_S_W-1:0] t1s,
    output logic             line,
    output logic             period_end
);

    logic [T_S_W-1:0] h;
    logic [T_S_W-1:0] s;
    logic [T_S_W-1:0] p;
    logic [T_S_W-1:0] pc;

    // Period stretches to cover the high time and is never shorter than one cycle.
    always_comb begin
        h = bit_val ? {1'b0, t1h} : {1'b0, t0h};
        s = bit_val ? t1s : t0s;
        p = s;
        if (h > p) begin
            p = h;
        end
        if (p == '0) begin
            p = 9'd1;
        end
    end

    assign line       = (pc < h);
    assign period_end = run && (pc == p - 9'd1);

    always_ff @(posedge clk) begin
        if (rst || start || period_end || !run) begin
            pc <= '0;
        end else begin
            pc <= pc + 9'd1;
        end
    end

endmodule

// File: rtl/ws28xx_bit_encoder.sv
// WS28xx single-wire encoder: accepts bytes over valid/ready, shifts them
// out MSB first and appends the low latch code after the last byte.
module ws28xx_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int CNT_W      = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [T_H_W-1:0] t0h_time_i,
    input  logic [T_S_W-1:0] t0s_time_i,
    input  logic [T_H_W-1:0] t1h_time_i,
    input  logic [T_S_W-1:0] t1s_time_i,
    input  logic             data_vld_i,
    input  logic [7:0]       data_i,
    input  logic             data_last_i,
    output logic             data_rdy_o,
    output logic             bit_o,
    output logic             busy_o,
    output logic             done_o
);

    enc_state_t       state;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             last_q;
    logic [CNT_W-1:0] lc;
    logic [T_H_W-1:0] t0h_q;
    logic [T_S_W-1:0] t0s_q;
    logic [T_H_W-1:0] t1h_q;
    logic [T_S_W-1:0] t1s_q;

    logic line;
    logic period_end;
    logic byte_end;
    logic accept;
    logic in_bit;

    assign in_bit     = (state == BIT);
    assign byte_end   = in_bit && (bit_cnt == 3'd0) && period_end;
    assign data_rdy_o = (state == IDLE) || byte_end;
    assign accept     = data_vld_i && data_rdy_o;
    assign busy_o     = (state != IDLE);

    ws28xx_bit_timer u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .start      (accept),
        .run        (in_bit),
        .bit_val    (shift[7]),
        .t0h        (t0h_q),
        .t0s        (t0s_q),
        .t1h        (t1h_q),
        .t1s        (t1s_q),
        .line       (line),
        .period_end (period_end)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            lc      <= '0;
            t0h_q   <= '0;
            t0s_q   <= '0;
            t1h_q   <= '0;
            t1s_q   <= '0;
            bit_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            bit_o  <= in_bit && line;
            done_o <= 1'b0;
            // Timing is frozen per byte so live register writes land cleanly.
            if (accept) begin
                state   <= BIT;
                shift   <= data_i;
                bit_cnt <= 3'd7;
                last_q  <= data_last_i;
                t0h_q   <= t0h_time_i;
                t0s_q   <= t0s_time_i;
                t1h_q   <= t1h_time_i;
                t1s_q   <= t1s_time_i;
            end else begin
                case (state)
                    BIT: begin
                        if (period_end) begin
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                state <= last_q ? LATCH : IDLE;
                                lc    <= '0;
                            end
                        end
                    end
                    LATCH: begin
                        if (lc == CNT_W'(RST_CYCLES - 1)) begin
                            done_o <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            lc <= lc + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ws28xx_bit_encoder.sv
// Scoreboard bench: stimulus pushes the expected bit_o/done_o timeline,
// a negedge monitor pops and compares it cycle by cycle.
module tb_ws28xx_bit_encoder;

    localparam int RST = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] t0h = 8'd2;
    logic [8:0] t0s = 9'd5;
    logic [7:0] t1h = 8'd4;
    logic [8:0] t1s = 9'd5;
    logic       vld = 1'b0;
    logic [7:0] data = 8'h00;
    logic       last = 1'b0;
    logic       data_rdy_o;
    logic       bit_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int cyc;
        bit b;
        bit d;
    } exp_t;

    exp_t q[$];

    ws28xx_bit_encoder #(.RST_CYCLES(RST), .CNT_W(12)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .t0h_time_i  (t0h),
        .t0s_time_i  (t0s),
        .t1h_time_i  (t1h),
        .t1s_time_i  (t1s),
        .data_vld_i  (vld),
        .data_i      (data),
        .data_last_i (last),
        .data_rdy_o  (data_rdy_o),
        .bit_o       (bit_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask

    // Reference waveform: each bit is max(S,H,1) cycles with the first H high.
    function automatic int push_byte(input int acc, input logic [7:0] d);
        int t, h, s, p;
        exp_t e;
        t = 0;
        for (int i = 7; i >= 0; i--) begin
            h = d[i] ? int'(t1h) : int'(t0h);
            s = d[i] ? int'(t1s) : int'(t0s);
            p = (s > h) ? s : h;
            if (p < 1) p = 1;
            for (int k = 0; k < p; k++) begin
                e.cyc = acc + 1 + t;
                e.b = (k < h);
                e.d = 1'b0;
                q.push_back(e);
                t++;
            end
        end
        return t;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit lst,
                             output int acc, output int tot);
        int n;
        n = 0;
        data = d;
        last = lst;
        vld = 1'b1;
        @(negedge clk);
        while (!data_rdy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!data_rdy_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cyc=%0d got=0 want=1", cyc);
            vld = 1'b0;
            acc = -1;
            tot = 0;
            return;
        end
        acc = cyc + 1;
        tot = push_byte(acc, d);
        @(posedge clk);
        #1;
        vld = 1'b0;
        last = 1'b0;
    endtask

    task automatic finish_frame(input int acc, input int tot,
                                input bit lst, input int gap);
        int endc;
        exp_t e;
        endc = acc + tot;
        if (lst) begin
            for (int m = 1; m <= RST; m++) begin
                e.cyc = endc + m;
                e.b = 1'b0;
                e.d = (m == RST);
                q.push_back(e);
            end
            endc += RST;
        end
        while (cyc < endc) @(posedge clk);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d got=%0d want=%0d",
                         cyc, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("bit_o", 32'(bit_o), 32'(e.b));
                chk("done_o", 32'(done_o), 32'(e.d));
                if (e.d) chk("busy_at_done", 32'(busy_o), 32'd0);
            end else begin
                chk("idle_bit_o", 32'(bit_o), 32'd0);
                chk("idle_done_o", 32'(done_o), 32'd0);
                if (q.size() == 0) chk("idle_busy_o", 32'(busy_o), 32'd0);
            end
        end
    end

    initial begin
        int a1, a2, n1, n2, nb, gap;
        bit lst, lb;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_o", 32'(bit_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        chk("rst_done_o", 32'(done_o), 32'd0);
        chk("rst_rdy", 32'(data_rdy_o), 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;

        // 0xA5 with latch
        send_byte(8'hA5, 1'b1, a1, n1);
        chk("a5_len", 32'(n1), 32'd40);
        finish_frame(a1, n1, 1'b1, 3);

        // back-to-back 0xFF, 0x00
        send_byte(8'hFF, 1'b0, a1, n1);
        send_byte(8'h00, 1'b1, a2, n2);
        chk("b2b_gap", 32'(a2 - a1), 32'd40);
        finish_frame(a2, n2, 1'b1, 2);

        // H=0 and H>=S boundaries
        t0h = 8'd0; t0s = 9'd3;
        send_byte(8'h00, 1'b0, a1, n1);
        chk("h0_len", 32'(n1), 32'd24);
        finish_frame(a1, n1, 1'b0, 2);
        t1h = 8'd7; t1s = 9'd3;
        send_byte(8'h80, 1'b0, a1, n1);
        finish_frame(a1, n1, 1'b0, 2);
        t0s = 9'd0; t1h = 8'd0; t1s = 9'd0;
        send_byte(8'h5A, 1'b1, a1, n1);
        chk("p1_len", 32'(n1), 32'd8);
        finish_frame(a1, n1, 1'b1, 2);

        // timing change mid-byte only affects the next byte
        t0h = 8'd2; t0s = 9'd5; t1h = 8'd4; t1s = 9'd5;
        send_byte(8'hFF, 1'b0, a1, n1);
        repeat (7) @(posedge clk);
        #1;
        t1h = 8'd1;
        send_byte(8'hFF, 1'b1, a2, n2);
        chk("snap_gap", 32'(a2 - a1), 32'd40);
        finish_frame(a2, n2, 1'b1, 2);

        // reset in the third bit period
        t1h = 8'd4;
        send_byte(8'hA5, 1'b1, a1, n1);
        while (cyc < a1 + 11) @(posedge clk);
        #1;
        mon_en = 1'b0;
        q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_bit_o", 32'(bit_o), 32'd0);
        chk("abort_busy_o", 32'(busy_o), 32'd0);
        chk("abort_rdy", 32'(data_rdy_o), 32'd1);
        chk("abort_done_o", 32'(done_o), 32'd0);
        mon_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        // last=0 then idle: no latch, busy drops at byte end
        send_byte(8'h3C, 1'b0, a1, n1);
        while (cyc < a1 + n1) @(posedge clk);
        @(negedge clk);
        chk("nolast_busy", 32'(busy_o), 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // randomized frames with occasional mid-frame timing writes
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 3);
            lst = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 4);
            t0h = 8'($urandom_range(0, 6)); t0s = 9'($urandom_range(0, 9));
            t1h = 8'($urandom_range(0, 6)); t1s = 9'($urandom_range(0, 9));
            for (int i = 0; i < nb; i++) begin
                d = 8'($urandom);
                lb = (i == nb - 1) ? lst : 1'($urandom_range(0, 1));
                send_byte(d, lb, a1, n1);
                if ($urandom_range(0, 2) == 0) begin
                    t0h = 8'($urandom_range(0, 6));
                    t1s = 9'($urandom_range(0, 9));
                end
            end
            if (a1 >= 0) finish_frame(a1, n1, lst, gap);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws28xx_bit_encoder.md
Name: ws28xx_bit_encoder

Overview:
Serialises pixel bytes into the single-wire NeoPixel (WS28xx) waveform for one channel. Sits directly downstream of regfile and consumes reg_t0h_time_o, reg_t0s_time_o, reg_t1h_time_o and reg_t1s_time_o as live timing inputs. Accepts bytes over a valid/ready handshake, shifts each byte out MSB first and appends the low latch/reset code after the byte flagged last.

Parameters:
RST_CYCLES, 4000, number of low cycles in the latch code after a frame (20 us at 200 MHz).
CNT_W, 12, width of the latch-code counter; must satisfy 2^CNT_W > RST_CYCLES.

Ports:
clk_i  in  1  clock, single domain.
rst_i  in  1  synchronous reset, active-high.
t0h_time_i  in  8  high cycles for a 0 bit.
t0s_time_i  in  9  total period cycles for a 0 bit.
t1h_time_i  in  8  high cycles for a 1 bit.
t1s_time_i  in  9  total period cycles for a 1 bit.
data_vld_i  in  1  byte valid.
data_i  in  8  byte to send, MSB first.
data_last_i  in  1  byte is the last of the frame; qualified by the handshake.
data_rdy_o  out  1  encoder can accept a byte this cycle.
bit_o  out  1  serial LED line, registered.
busy_o  out  1  a byte or latch code is in progress.
done_o  out  1  one-cycle pulse when the latch code completes.

Behaviour:
- Reset (rst_i=1 on a clock edge): state=IDLE; bit_o=0, busy_o=0, done_o=0. data_rdy_o is combinational and therefore reads 1 in IDLE. Reset mid-byte or mid-latch aborts immediately, and bit_o is 0 from the next edge.
- FSM states: IDLE, BIT, LATCH.
- IDLE:
  - data_rdy_o=1.
  - On data_vld_i & data_rdy_o: load the shift register with data_i, bit_cnt=7, latch last_q=data_last_i, snapshot all four timing inputs, go to BIT.
  - bit_o rises on the edge after the acceptance edge (1-cycle latency).
- BIT:
  - Current bit b = shift[7].
  - Per-bit high count H = b ? t1h : t0h, zero-extended to 9 bits.
  - Per-bit period P = max(b ? t1s : t0s, H, 1). Boundary cases: H=0 gives a line low for the whole period; H>=S gives high for the whole period of H cycles; S=0 gives P = max(H,1).
  - Period counter pc runs 0..P-1. bit_o = (pc < H).
  - When pc = P-1: pc=0, shift left, bit_cnt-1.
- Byte end (bit_cnt=0 and pc=P-1):
  - data_rdy_o=1 in that cycle only.
  - If data_vld_i is high, the next byte loads with no gap cycle (back-to-back bytes), and the snapshot is refreshed.
  - Otherwise: if last_q=1, go to LATCH; if last_q=0, go to IDLE. bit_o is then 0.
- LATCH:
  - bit_o=0 for exactly RST_CYCLES cycles. data_rdy_o=0.
  - On the final cycle, assert done_o for one cycle and go to IDLE.
- Outputs:
  - busy_o = (state != IDLE).
  - data_rdy_o=0 at all times other than IDLE and the byte-end cycle.
- Regfile writes to the timing inputs mid-byte have no effect until the next byte is accepted (snapshot rule).
- data_last_i is ignored unless the handshake completes.
- Counters never wrap: pc is 9 bits and P <= 511.

Decomposition:
- Shared package neopixel_pkg holds:
  - typedef enum logic [1:0] {IDLE, BIT, LATCH} enc_state_t;
  - constants T_H_W=8 and T_S_W=9, also used by regfile.
  - the RST_CYCLES default.
- Natural sub-module: ws28xx_bit_timer. It computes H and P and runs pc, with inputs bit/timing/start and outputs line/period_end. The FSM and shift register stay in ws28xx_bit_encoder.

Test Plan:
- Timing t0h=2, t0s=5, t1h=4, t1s=5, RST_CYCLES=10. Send 0xA5 with last=1 -> bit_o shows 8 periods of 5 cycles each. High runs are 4,2,4,2,2,4,2,4 cycles. This is followed by 10 low cycles, then done_o=1 for 1 cycle, busy_o=0.
- Bytes 0xFF then 0x00 (last on the second), data_vld_i held -> data_rdy_o pulses exactly on the last cycle of byte 1. No idle gap: byte 2 period 1 starts on the next edge. Total 80 cycles, then latch.
- t0h=0, t0s=3 with byte 0x00 -> bit_o stays 0 for 24 cycles. Set t1h=7, t1s=3 with byte 0x80 -> first bit high for 7 cycles.
- Change t1h from 4 to 1 mid-byte while sending 0xFF -> every bit of the current byte keeps a high time of 4. The next byte uses 1.
- Assert rst_i in the 3rd bit period -> bit_o=0, busy_o=0, data_rdy_o=1 one edge later. No done_o pulse.
- Byte with last=0 followed by 20 idle cycles -> no latch code, no done_o. busy_o falls right after the byte ends.
